rs_issue_queue: RTL
===================

RS_ISSUE_QUEUE -- requirements
Module: rs_issue_queue

Interface
REQ-001 Parameter WORD_SIZE, 32: operand data width.
REQ-002 Parameter NUM_P_REGS, 64: physical register count; PREG_W = $clog2(NUM_P_REGS).
REQ-003 Parameter NUM_ENTRIES, 16: reservation-station rows; SHALL be >= DISPATCH_WIDTH.
REQ-004 Parameter DISPATCH_WIDTH, 2: dispatch lanes per cycle.
REQ-005 Parameter ISSUE_WIDTH, 2: functional-unit issue ports.
REQ-006 Parameter NUM_WB, 2: writeback/wakeup broadcast ports.
REQ-007 Parameter PAYLOAD_W, 16: opaque per-instruction payload (alu_op, contr, rob_index), passed through unchanged.
REQ-008 clk_i  in  1  single clock; all state updates on rising edge.
REQ-009 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-010 flush_i  in  1  invalidate all entries.
REQ-011 disp_valid_i  in  DISPATCH_WIDTH  per-lane dispatch request.
REQ-012 disp_ready_o  out  1  queue accepts a full dispatch group this cycle.
REQ-013 disp_dest_i  in  DISPATCH_WIDTH*PREG_W  destination tag per lane.
REQ-014 disp_src_tag_i  in  DISPATCH_WIDTH*2*PREG_W  source tags (src0, src1) per lane.
REQ-015 disp_src_rdy_i  in  DISPATCH_WIDTH*2  source already available (immediate or x0 included).
REQ-016 disp_src_val_i  in  DISPATCH_WIDTH*2*WORD_SIZE  source value, meaningful when ready.
REQ-017 disp_payload_i  in  DISPATCH_WIDTH*PAYLOAD_W  payload per lane.
REQ-018 wb_valid_i / wb_tag_i / wb_data_i  in  NUM_WB / NUM_WB*PREG_W / NUM_WB*WORD_SIZE  result broadcasts.
REQ-019 iss_valid_o  out  ISSUE_WIDTH  issue port k carries an instruction.
REQ-020 iss_ready_i  in  ISSUE_WIDTH  FU k accepts this cycle.
REQ-021 iss_op0_o / iss_op1_o / iss_dest_o / iss_payload_o  out  per port WORD_SIZE / WORD_SIZE / PREG_W / PAYLOAD_W.
REQ-022 count_o  out  $clog2(NUM_ENTRIES+1)  occupied entries (registered).

Function
REQ-023 Entry state: valid, dest, payload, and per source tag, rdy, val.
REQ-024 disp_ready_o SHALL be high iff free entries at cycle start >= DISPATCH_WIDTH; combinational from registered state only.
REQ-025 Lane d accepted iff disp_valid_i[d] and disp_ready_o; written into the d-th lowest-index entry free at cycle start (lanes compacted over valid lanes only).
REQ-026 Entries freed by issue in cycle t SHALL NOT be reused by dispatch before cycle t+1.
REQ-027 Wakeup: each valid entry source with rdy=0 whose tag equals wb_tag_i[w] with wb_valid_i[w] SHALL set rdy=1 and capture wb_data_i[w] at the edge.
REQ-028 Dispatch bypass: a dispatched source with rdy=0 matching a same-cycle broadcast SHALL be written with rdy=1 and the broadcast value.
REQ-029 Multiple broadcasts matching one tag: lowest-index wb port wins.
REQ-030 An entry is ready when valid and both source rdy bits are set in registered state; wakeup at edge t makes it issuable in cycle t+1 (one-cycle wakeup latency).
REQ-031 Select: port k SHALL present the k-th lowest-index ready entry; iss_valid_o[k]=0 if fewer than k+1 ready entries.
REQ-032 iss_op0_o/iss_op1_o = src0/src1 val; iss_dest_o, iss_payload_o from entry; iss_valid_o independent of iss_ready_i.
REQ-033 Entry removed (valid=0) at the edge where its port has iss_valid_o&iss_ready_i; otherwise retained and re-selected next cycle.
REQ-034 count_o next = count - issued + accepted dispatches; never exceeds NUM_ENTRIES, never underflows.
REQ-035 flush_i: iss_valid_o forced 0, disp_ready_o forced 0, all entries invalidated at edge, count_o 0 next cycle; wakeup ignored.

Reset
REQ-036 rst_ni low SHALL immediately clear all entry valid bits and count_o to 0, including mid-dispatch/issue.
REQ-037 During/after reset: iss_valid_o = 0, disp_ready_o = 1, count_o = 0; source values need no reset.

Verification
REQ-038 Reset, dispatch 2 lanes both sources rdy (values 5,7 and 3,4) -> next cycle iss_valid_o=2'b11, port0 op0=5 op1=7, port1 op0=3 op1=4; iss_ready_i=11 -> count_o 0.
REQ-039 Dispatch src0 tag 9 rdy=0; broadcast tag 9 data 0xAA two cycles later -> iss_valid_o[0] one cycle after broadcast, op0=0xAA.
REQ-040 Dispatch tag 12 rdy=0 with same-cycle wb tag 12 data 0x55 -> entry issuable next cycle with op0=0x55.
REQ-041 Fill to NUM_ENTRIES-1 -> disp_ready_o=0; issue one with ready -> disp_ready_o=1 the following cycle, not the same.
REQ-042 Ready entry, iss_ready_i[0]=0 for 3 cycles -> same entry held stable on port0, count_o unchanged; then ready -> removed.
REQ-043 8 entries occupied, assert flush_i concurrent with dispatch and broadcast -> iss_valid_o=0 that cycle, count_o=0 next; async rst_ni pulse mid-cycle -> outputs reset immediately.

Source files
------------

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: multi-lane dispatch into the lowest free rows, tag wakeup
// from writeback broadcasts, and lowest-index-first select onto ISSUE_WIDTH ports.
module rs_issue_queue #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned NUM_P_REGS     = 64,
    parameter int unsigned NUM_ENTRIES    = 16,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH    = 2,
    parameter int unsigned NUM_WB         = 2,
    parameter int unsigned PAYLOAD_W      = 16,
    localparam int unsigned PREG_W        = $clog2(NUM_P_REGS),
    localparam int unsigned CNT_W         = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic [DISPATCH_WIDTH-1:0]             disp_valid_i,
    output logic                                  disp_ready_o,
    input  logic [DISPATCH_WIDTH*PREG_W-1:0]      disp_dest_i,
    input  logic [DISPATCH_WIDTH*2*PREG_W-1:0]    disp_src_tag_i,
    input  logic [DISPATCH_WIDTH*2-1:0]           disp_src_rdy_i,
    input  logic [DISPATCH_WIDTH*2*WORD_SIZE-1:0] disp_src_val_i,
    input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0]   disp_payload_i,
    input  logic [NUM_WB-1:0]                     wb_valid_i,
    input  logic [NUM_WB*PREG_W-1:0]              wb_tag_i,
    input  logic [NUM_WB*WORD_SIZE-1:0]           wb_data_i,
    output logic [ISSUE_WIDTH-1:0]                iss_valid_o,
    input  logic [ISSUE_WIDTH-1:0]                iss_ready_i,
    output logic [ISSUE_WIDTH*WORD_SIZE-1:0]      iss_op0_o,
    output logic [ISSUE_WIDTH*WORD_SIZE-1:0]      iss_op1_o,
    output logic [ISSUE_WIDTH*PREG_W-1:0]         iss_dest_o,
    output logic [ISSUE_WIDTH*PAYLOAD_W-1:0]      iss_payload_o,
    output logic [CNT_W-1:0]                      count_o
);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PREG_W-1:0]      dest_q    [NUM_ENTRIES];
    logic [PREG_W-1:0]      dest_d    [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   payload_q [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   payload_d [NUM_ENTRIES];
    logic [PREG_W-1:0]      tag_q     [NUM_ENTRIES][2];
    logic [PREG_W-1:0]      tag_d     [NUM_ENTRIES][2];
    logic [1:0]             rdy_q     [NUM_ENTRIES];
    logic [1:0]             rdy_d     [NUM_ENTRIES];
    logic [WORD_SIZE-1:0]   val_q     [NUM_ENTRIES][2];
    logic [WORD_SIZE-1:0]   val_d     [NUM_ENTRIES][2];

    logic [NUM_ENTRIES-1:0] issued;
    logic [CNT_W-1:0]       n_issued, n_accepted;

    // Returns {hit, data}; scanning high to low lets the lowest-index port win.
    function automatic logic [WORD_SIZE:0] wb_match(
        input logic [PREG_W-1:0]           tag,
        input logic [NUM_WB-1:0]           wb_valid,
        input logic [NUM_WB*PREG_W-1:0]    wb_tag,
        input logic [NUM_WB*WORD_SIZE-1:0] wb_data
    );
        logic [WORD_SIZE:0] hit;
        hit = '0;
        for (int w = NUM_WB - 1; w >= 0; w--) begin
            if (wb_valid[w] && (wb_tag[w*PREG_W +: PREG_W] == tag)) begin
                hit = {1'b1, wb_data[w*WORD_SIZE +: WORD_SIZE]};
            end
        end
        return hit;
    endfunction

    // Only registered occupancy decides acceptance, so issue frees a row for the next cycle.
    assign disp_ready_o = !flush_i &&
        ((32'(NUM_ENTRIES) - 32'(count_q)) >= 32'(DISPATCH_WIDTH));
    assign count_o = count_q;

    always_comb begin
        int n;
        iss_valid_o   = '0;
        iss_op0_o     = '0;
        iss_op1_o     = '0;
        iss_dest_o    = '0;
        iss_payload_o = '0;
        issued        = '0;
        n_issued      = '0;
        n = 0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (valid_q[i] && (&rdy_q[i])) begin
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    if ((n == k) && !flush_i) begin
                        iss_valid_o[k]                         = 1'b1;
                        iss_op0_o[k*WORD_SIZE +: WORD_SIZE]    = val_q[i][0];
                        iss_op1_o[k*WORD_SIZE +: WORD_SIZE]    = val_q[i][1];
                        iss_dest_o[k*PREG_W +: PREG_W]         = dest_q[i];
                        iss_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[i];
                        if (iss_ready_i[k]) begin
                            issued[i] = 1'b1;
                            n_issued  = n_issued + CNT_W'(1);
                        end
                    end
                end
                n = n + 1;
            end
        end
    end

    always_comb begin
        logic [WORD_SIZE:0] hit;
        int acc;
        int f;
        valid_d    = valid_q & ~issued;
        dest_d     = dest_q;
        payload_d  = payload_q;
        tag_d      = tag_q;
        rdy_d      = rdy_q;
        val_d      = val_q;
        n_accepted = '0;
        hit        = '0;
        acc        = 0;
        f          = 0;

        for (int i = 0; i < NUM_ENTRIES; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (valid_q[i] && !rdy_q[i][s]) begin
                    hit = wb_match(tag_q[i][s], wb_valid_i, wb_tag_i, wb_data_i);
                    if (hit[WORD_SIZE]) begin
                        rdy_d[i][s] = 1'b1;
                        val_d[i][s] = hit[WORD_SIZE-1:0];
                    end
                end
            end
        end

        // Valid lanes are compacted: the acc-th accepted lane takes the acc-th free row.
        for (int d = 0; d < DISPATCH_WIDTH; d++) begin
            if (disp_valid_i[d] && disp_ready_o) begin
                f = 0;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (!valid_q[i]) begin
                        if (f == acc) begin
                            valid_d[i]   = 1'b1;
                            dest_d[i]    = disp_dest_i[d*PREG_W +: PREG_W];
                            payload_d[i] = disp_payload_i[d*PAYLOAD_W +: PAYLOAD_W];
                            for (int s = 0; s < 2; s++) begin
                                tag_d[i][s] = disp_src_tag_i[(2*d+s)*PREG_W +: PREG_W];
                                hit = wb_match(tag_d[i][s], wb_valid_i, wb_tag_i, wb_data_i);
                                if (!disp_src_rdy_i[2*d+s] && hit[WORD_SIZE]) begin
                                    rdy_d[i][s] = 1'b1;
                                    val_d[i][s] = hit[WORD_SIZE-1:0];
                                end else begin
                                    rdy_d[i][s] = disp_src_rdy_i[2*d+s];
                                    val_d[i][s] = disp_src_val_i[(2*d+s)*WORD_SIZE +: WORD_SIZE];
                                end
                            end
                        end
                        f = f + 1;
                    end
                end
                acc        = acc + 1;
                n_accepted = n_accepted + CNT_W'(1);
            end
        end

        count_d = count_q - n_issued + n_accepted;
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Row contents are qualified by valid_q and need no reset.
    always_ff @(posedge clk_i) begin
        dest_q    <= dest_d;
        payload_q <= payload_d;
        tag_q     <= tag_d;
        rdy_q     <= rdy_d;
        val_q     <= val_d;
    end

endmodule
